alu_cmd_issuer: RTL and testbench

Initiator-side driver for the two-cycle ALU `op_start` interface.
- Accepts operation/operand commands over a valid/ready port.
- Drives the ALU's `op_start`, `operation`, `operand_a` and `operand_b` with exactly one operation in flight.
- Captures `result` after a fixed latency and queues it in a small response FIFO with valid/ready output.
- Sits between a command source (sequencer or CPU bridge) and the ALU, replacing bench-side stimulus timing in hardware.

---
 rtl/alu_cmd_issuer_if.sv | 36 +++
 rtl/alu_cmd_issuer.sv | 111 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and response signals of the ALU command issuer
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_operation;
  logic [DATA_W-1:0]     cmd_operand_a;
  logic [DATA_W-1:0]     cmd_operand_b;
  logic                  alu_op_start;
  logic [1:0]            alu_operation;
  logic [DATA_W-1:0]     alu_operand_a;
  logic [DATA_W-1:0]     alu_operand_b;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_result;
  logic [1:0]            rsp_operation;
  logic [15:0]           issued_count;

  // Environment side: command source, ALU and response consumer
  modport master (
    output cmd_valid, cmd_operation, cmd_operand_a, cmd_operand_b,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_op_start, alu_operation, alu_operand_a, alu_operand_b,
    input  rsp_valid, rsp_result, rsp_operation, issued_count
  );

  // Issuer side
  modport slave (
    input  cmd_valid, cmd_operation, cmd_operand_a, cmd_operand_b,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_op_start, alu_operation, alu_operand_a, alu_operand_b,
    output rsp_valid, rsp_result, rsp_operation, issued_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one ALU operation at a time and queues its result
module alu_cmd_issuer #(
  parameter int DATA_W    = 8,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_cmd_issuer_if.slave bus
);
  localparam int RES_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int ENT_W = RES_W + 2;
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(RSP_DEPTH);
  localparam logic [3:0]     WAIT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         wait_q;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [15:0]        issued_q;
  logic [ENT_W-1:0]   mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               ready, accept, push, pop, rsp_valid;

  // Ready is gated by rst_n so it reads 0 while reset is held even though state is IDLE
  assign ready     = rst_n && (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign accept    = ready && bus.cmd_valid;
  assign push      = (state_q == S_CAPTURE);
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;

  assign bus.cmd_ready     = ready;
  assign bus.alu_op_start  = (state_q == S_START);
  assign bus.alu_operation = op_q;
  assign bus.alu_operand_a = a_q;
  assign bus.alu_operand_b = b_q;
  assign bus.issued_count  = issued_q;
  assign bus.rsp_valid     = rsp_valid;
  assign {bus.rsp_operation, bus.rsp_result} = rsp_valid ? mem_q[rd_ptr_q] : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept -> start pulse -> wait out the ALU latency -> capture
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_START;
      S_START:   state_d = (LATENCY == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wait_q == 4'd1) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Latency counter, loaded in START and counted down while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_q <= '0;
    else if (state_q == S_START)  wait_q <= WAIT_LOAD;
    else if (state_q == S_WAIT)   wait_q <= wait_q - 4'd1;
  end

  // Operation/operand registers and issue counter; only change on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      issued_q <= '0;
    end else if (accept) begin
      op_q     <= bus.cmd_operation;
      a_q      <= bus.cmd_operand_a;
      b_q      <= bus.cmd_operand_b;
      issued_q <= issued_q + 16'd1;
    end
  end

  // Response storage; contents need no reset because outputs are masked when empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_q, bus.alu_result};
  end

  // Response FIFO pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is reserved at accept, so a capture can never land in a full FIFO
  push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a behavioural ALU
module tb_alu_cmd_issuer;
  localparam int DATA_W    = 8;
  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;
  localparam int RES_W     = 2 * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.DATA_W(DATA_W)) bus ();

  alu_cmd_issuer #(.DATA_W(DATA_W), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RES_W-1:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return 16'(a) + 16'(b);
      2'b01:   return 16'(a) * 16'(b);
      2'b10:   return 16'(a | b);
      default: return 16'(a & b);
    endcase
  endfunction

  // Behavioural ALU: result appears LATENCY cycles after a sampled op_start, junk otherwise
  logic [RES_W-1:0] alu_pipe [LATENCY];
  always @(posedge clk) begin
    alu_pipe[0] <= bus.alu_op_start ?
                   ref_alu(bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b) :
                   16'($urandom);
    for (int i = 1; i < LATENCY; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_result = alu_pipe[LATENCY-1];

  logic [17:0] exp_q [$];
  logic [15:0] popped_q [$];
  int          acc_cyc [$];
  int          acc_total = 0;
  logic [15:0] base = 16'h0;
  logic        start_due = 1'b0;
  logic [17:0] last_cmd = '0;
  logic        rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Holds cmd_valid with the given command until it is accepted; returns in the START cycle
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.cmd_valid     = 1'b1;
    bus.cmd_operation = op;
    bus.cmd_operand_a = a;
    bus.cmd_operand_b = b;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    rand_mode     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.rsp_valid || !bus.cmd_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: records accepts into the scoreboard and compares every popped response
  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        start_due = 1'b0;
        acc_total = 0;
        continue;
      end
      if (start_due || bus.alu_op_start) begin
        chk("op_start_timing", 32'(bus.alu_op_start), 32'(start_due));
        if (start_due)
          chk("alu_regs", {bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b}, last_cmd);
      end
      start_due = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        chk("issued_count", 32'(bus.issued_count), 32'(16'(base + 16'(acc_total))));
        acc_total++;
        acc_cyc.push_back(cyc);
        last_cmd  = {bus.cmd_operation, bus.cmd_operand_a, bus.cmd_operand_b};
        start_due = 1'b1;
        exp_q.push_back({bus.cmd_operation,
                         ref_alu(bus.cmd_operation, bus.cmd_operand_a, bus.cmd_operand_b)});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {bus.rsp_operation, bus.rsp_result}, 32'h3FFFF + 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {bus.rsp_operation, bus.rsp_result}, e);
          popped_q.push_back(bus.rsp_result);
        end
      end
    end
  endtask

  initial begin
    logic [3:0] pat;
    int seen;
    int acc0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_operation = 2'b00;
    bus.cmd_operand_a = '0;
    bus.cmd_operand_b = '0;
    bus.rsp_ready     = 1'b0;

    fork
      monitor();
      begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, errors=%0d", errors);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    #2;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_op_start", 32'(bus.alu_op_start), 32'd0);
    chk("rst_alu_regs", {bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b}, 32'd0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_operation, bus.rsp_result}, 32'd0);
    chk("rst_issued", 32'(bus.issued_count), 32'd0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    tick();

    // ADD FF+01: response 4 cycles after accept
    bus.rsp_ready = 1'b1;
    send(2'b00, 8'hFF, 8'h01);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[k] = bus.rsp_valid;
      if (k == 3) chk("add_result", {bus.rsp_operation, bus.rsp_result}, 32'h0100);
    end
    chk("add_latency", 32'(pat), 32'b1000);
    drain();

    // Back-to-back MULT, OR, AND with cmd_valid held
    acc_cyc.delete();
    popped_q.delete();
    send(2'b01, 8'hFF, 8'hFF);
    send(2'b10, 8'hA5, 8'h5A);
    send(2'b11, 8'hF0, 8'h3C);
    drain();
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end
    chk("b2b_results", popped_q.size() == 3 ?
        32'({popped_q[0] == 16'hFE01, popped_q[1] == 16'h00FF, popped_q[2] == 16'h0030}) : 32'd0,
        32'b111);
    chk("b2b_issued", 32'(bus.issued_count), 32'd4);

    // Full FIFO blocks the fifth command until one pop
    bus.rsp_ready = 1'b0;
    acc0 = acc_total;
    for (int i = 0; i < 4; i++) send(2'(i), 8'(8'h11 * (i + 1)), 8'(8'h0F + i));
    bus.cmd_operation = 2'b01;
    bus.cmd_operand_a = 8'h0C;
    bus.cmd_operand_b = 8'h0D;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cmd_ready) seen++;
    end
    chk("full_blocks_ready", 32'(seen), 32'd0);
    chk("full_accepts", 32'(acc_total - acc0), 32'd4);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("ready_after_pop", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("fifth_accepted", 32'(acc_total - acc0), 32'd5);
    drain();

    // Simultaneous push and pop with one entry held
    bus.rsp_ready = 1'b0;
    send(2'b00, 8'h03, 8'h04);
    bus.cmd_valid = 1'b0;
    seen = 0;
    while (!bus.rsp_valid && seen < 20) begin
      tick();
      seen++;
    end
    send(2'b01, 8'h07, 8'h09);
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pp_head_before", {bus.rsp_valid, bus.rsp_operation, bus.rsp_result}, {1'b1, 2'b00, 16'h0007});
    tick();
    bus.rsp_ready = 1'b0;
    chk("pp_head_after", {bus.rsp_valid, bus.rsp_operation, bus.rsp_result}, {1'b1, 2'b01, 16'h003F});
    drain();

    // Reset during WAIT discards the in-flight ADD
    send(2'b00, 8'h10, 8'h20);
    bus.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    base  = 16'h0;
    #1;
    chk("mid_rst_start_ready", {bus.alu_op_start, bus.cmd_ready}, 32'd0);
    chk("mid_rst_alu_regs", {bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b}, 32'd0);
    chk("mid_rst_rsp", {bus.rsp_valid, bus.rsp_operation, bus.rsp_result}, 32'd0);
    chk("mid_rst_issued", 32'(bus.issued_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    popped_q.delete();
    send(2'b00, 8'h10, 8'h20);
    drain();
    chk("post_reset_result", popped_q.size() == 1 ? 32'(popped_q[0]) : 32'hDEAD, 32'h0030);

    // issued_count wrap FFFF -> 0000
    force dut.issued_q = 16'hFFFF;
    #1 release dut.issued_q;
    base = 16'hFFFF - 16'(acc_total);
    chk("preload_issued", 32'(bus.issued_count), 32'hFFFF);
    send(2'b10, 8'h01, 8'h02);
    bus.cmd_valid = 1'b0;
    chk("issued_wrap", 32'(bus.issued_count), 32'h0000);
    drain();

    // Randomised traffic with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 120; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      bus.cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
